// File: rtl/store_align_unit_pkg.sv
// rtl/store_align_unit_pkg.sv - shared types and helpers for the store alignment path
package store_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  // Lanes off..off+count-1, clipped to the nb lanes that exist on the bus.
  function automatic logic [7:0] lane_mask(input logic [3:0] off, input logic [3:0] count,
                                           input int nb);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < nb && i >= int'(off) && i < int'(off) + int'(count)) begin
        m[i] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/store_align_unit_if.sv
// rtl/store_align_unit_if.sv - request and memory-beat signals of the store alignment unit
interface store_align_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [NB-1:0]     mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic              done;
  logic              misalign_exc;
  logic [ADDR_W-1:0] bad_addr;

  modport master (
    output req_valid, req_size, req_addr, req_wdata, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_be, mem_wdata, done, misalign_exc, bad_addr
  );

  modport slave (
    input  req_valid, req_size, req_addr, req_wdata, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_be, mem_wdata, done, misalign_exc, bad_addr
  );

endinterface

// File: rtl/store_align_unit_lane_gen.sv
// rtl/store_align_unit_lane_gen.sv - combinational lane enables and shift for one beat
module store_lane_gen
  import store_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB    = DATA_W / 8,
  localparam int OW    = $clog2(NB),
  localparam int SHW   = OW + 3
) (
  input  logic [OW-1:0]  i_off,
  input  logic [1:0]     i_size,
  input  logic           i_beat,
  output logic [NB-1:0]  o_be,
  output logic [SHW-1:0] o_shift,
  output logic           o_crosses,
  output logic           o_illegal
);

  logic [4:0] w_bytes;
  logic [4:0] w_last;

  always_comb begin
    w_bytes = 5'd1;
    case (i_size)
      SZ_BYTE:  w_bytes = 5'd1;
      SZ_HALF:  w_bytes = 5'd2;
      SZ_WORD:  w_bytes = 5'd4;
      SZ_DWORD: w_bytes = 5'd8;
      default:  w_bytes = 5'd1;
    endcase
    w_last    = 5'(i_off) + w_bytes - 5'd1;
    o_illegal = (w_bytes > 5'(NB));
    o_crosses = !o_illegal && (w_last >= 5'(NB));
    // Beat 0 shifts left into the upper lanes; beat 1 brings the overflow bytes down to lane 0.
    if (!i_beat) begin
      o_be    = NB'(lane_mask(4'(i_off), w_bytes[3:0], NB));
      o_shift = {i_off, 3'b000};
    end else begin
      o_be    = NB'(lane_mask(4'd0, 4'(w_last - 5'(NB) + 5'd1), NB));
      o_shift = SHW'(8 * (NB - int'(i_off)));
    end
  end

endmodule

// File: rtl/store_align_unit.sv
// rtl/store_align_unit.sv - store path from MEM stage to data memory, splitting or rejecting
// stores that cross a bus-word boundary
module store_align_unit
  import store_pkg::*;
#(
  parameter int DATA_W           = 32,
  parameter int ADDR_W           = 32,
  parameter int SPLIT_MISALIGNED = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  store_align_unit_if.slave bus
);

  localparam int NB  = DATA_W / 8;
  localparam int OW  = $clog2(NB);
  localparam int SHW = OW + 3;

  state_t            r_state;
  logic [1:0]        r_size;
  logic [OW-1:0]     r_off;
  logic [DATA_W-1:0] r_wdata;
  logic              r_mem_valid;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [NB-1:0]     r_mem_be;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_done;
  logic              r_exc;
  logic [ADDR_W-1:0] r_bad_addr;

  logic              w_idle;
  logic              w_beat;
  logic [OW-1:0]     w_off;
  logic [1:0]        w_size;
  logic [NB-1:0]     w_be;
  logic [SHW-1:0]    w_shift;
  logic              w_crosses;
  logic              w_illegal;
  logic              w_reject;
  logic [DATA_W-1:0] w_src;
  logic [DATA_W-1:0] w_shifted;
  logic [DATA_W-1:0] w_lane_mask;
  logic [DATA_W-1:0] w_lane_data;
  logic [ADDR_W-1:0] w_aligned;

  // While idle the lane generator looks at the incoming request (beat 0); afterwards it
  // looks at the latched request and produces beat 1.
  assign w_idle = (r_state == IDLE);
  assign w_beat = !w_idle;
  assign w_off  = w_idle ? bus.req_addr[OW-1:0] : r_off;
  assign w_size = w_idle ? bus.req_size : r_size;
  assign w_src  = w_idle ? bus.req_wdata : r_wdata;

  store_lane_gen #(
    .DATA_W(DATA_W)
  ) u_lane_gen (
    .i_off    (w_off),
    .i_size   (w_size),
    .i_beat   (w_beat),
    .o_be     (w_be),
    .o_shift  (w_shift),
    .o_crosses(w_crosses),
    .o_illegal(w_illegal)
  );

  always_comb begin
    w_lane_mask = '0;
    w_shifted   = w_beat ? (w_src >> w_shift) : (w_src << w_shift);
    for (int i = 0; i < NB; i++) begin
      w_lane_mask[8*i +: 8] = {8{w_be[i]}};
    end
    w_lane_data = w_shifted & w_lane_mask;
  end

  assign w_aligned = {bus.req_addr[ADDR_W-1:OW], {OW{1'b0}}};
  assign w_reject  = w_illegal || (w_crosses && (SPLIT_MISALIGNED == 0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_size      <= '0;
      r_off       <= '0;
      r_wdata     <= '0;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
      r_done      <= 1'b0;
      r_exc       <= 1'b0;
      r_bad_addr  <= '0;
    end else begin
      r_done <= 1'b0;
      r_exc  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_size  <= bus.req_size;
            r_off   <= bus.req_addr[OW-1:0];
            r_wdata <= bus.req_wdata;
            if (w_reject) begin
              r_exc      <= 1'b1;
              r_bad_addr <= bus.req_addr;
            end else begin
              r_mem_valid <= 1'b1;
              r_mem_addr  <= w_aligned;
              r_mem_be    <= w_be;
              r_mem_wdata <= w_lane_data;
              r_state     <= BEAT0;
            end
          end
        end
        BEAT0: begin
          if (bus.mem_ready) begin
            if (w_crosses) begin
              r_mem_addr  <= r_mem_addr + ADDR_W'(NB);
              r_mem_be    <= w_be;
              r_mem_wdata <= w_lane_data;
              r_state     <= BEAT1;
            end else begin
              r_mem_valid <= 1'b0;
              r_mem_be    <= '0;
              r_mem_wdata <= '0;
              r_done      <= 1'b1;
              r_state     <= IDLE;
            end
          end
        end
        BEAT1: begin
          if (bus.mem_ready) begin
            r_mem_valid <= 1'b0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
            r_done      <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_mem_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready    = w_idle && rst_n;
  assign bus.mem_valid    = r_mem_valid;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.mem_be       = r_mem_be;
  assign bus.mem_wdata    = r_mem_wdata;
  assign bus.done         = r_done;
  assign bus.misalign_exc = r_exc;
  assign bus.bad_addr     = r_bad_addr;

endmodule

// File: tb/tb_store_align_unit.sv
// tb/tb_store_align_unit.sv - bench for store_align_unit: 32-bit split, 32-bit reject, 64-bit split
module tb_store_align_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  store_align_unit_if #(.DATA_W(32), .ADDR_W(32)) bus0 ();
  store_align_unit_if #(.DATA_W(32), .ADDR_W(32)) bus1 ();
  store_align_unit_if #(.DATA_W(64), .ADDR_W(32)) bus2 ();

  store_align_unit #(.DATA_W(32), .ADDR_W(32), .SPLIT_MISALIGNED(1)) u_s32 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  store_align_unit #(.DATA_W(32), .ADDR_W(32), .SPLIT_MISALIGNED(0)) u_r32 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));
  store_align_unit #(.DATA_W(64), .ADDR_W(32), .SPLIT_MISALIGNED(1)) u_s64 (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  logic        d_valid [3];
  logic [1:0]  d_size  [3];
  logic [31:0] d_addr  [3];
  logic [63:0] d_wdata [3];
  logic        d_mready[3];

  assign bus0.req_valid = d_valid[0];
  assign bus0.req_size  = d_size[0];
  assign bus0.req_addr  = d_addr[0];
  assign bus0.req_wdata = d_wdata[0][31:0];
  assign bus0.mem_ready = d_mready[0];
  assign bus1.req_valid = d_valid[1];
  assign bus1.req_size  = d_size[1];
  assign bus1.req_addr  = d_addr[1];
  assign bus1.req_wdata = d_wdata[1][31:0];
  assign bus1.mem_ready = d_mready[1];
  assign bus2.req_valid = d_valid[2];
  assign bus2.req_size  = d_size[2];
  assign bus2.req_addr  = d_addr[2];
  assign bus2.req_wdata = d_wdata[2];
  assign bus2.mem_ready = d_mready[2];

  logic        o_ready[3], o_valid[3], o_done[3], o_exc[3];
  logic [31:0] o_addr [3], o_bad[3];
  logic [7:0]  o_be   [3];
  logic [63:0] o_wdata[3];

  assign o_ready[0] = bus0.req_ready;
  assign o_valid[0] = bus0.mem_valid;
  assign o_done[0]  = bus0.done;
  assign o_exc[0]   = bus0.misalign_exc;
  assign o_addr[0]  = bus0.mem_addr;
  assign o_bad[0]   = bus0.bad_addr;
  assign o_be[0]    = {4'd0, bus0.mem_be};
  assign o_wdata[0] = {32'd0, bus0.mem_wdata};
  assign o_ready[1] = bus1.req_ready;
  assign o_valid[1] = bus1.mem_valid;
  assign o_done[1]  = bus1.done;
  assign o_exc[1]   = bus1.misalign_exc;
  assign o_addr[1]  = bus1.mem_addr;
  assign o_bad[1]   = bus1.bad_addr;
  assign o_be[1]    = {4'd0, bus1.mem_be};
  assign o_wdata[1] = {32'd0, bus1.mem_wdata};
  assign o_ready[2] = bus2.req_ready;
  assign o_valid[2] = bus2.mem_valid;
  assign o_done[2]  = bus2.done;
  assign o_exc[2]   = bus2.misalign_exc;
  assign o_addr[2]  = bus2.mem_addr;
  assign o_bad[2]   = bus2.bad_addr;
  assign o_be[2]    = bus2.mem_be;
  assign o_wdata[2] = bus2.mem_wdata;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: place each stored byte at its own byte address and group by bus word.
  int          m_beats;
  logic [31:0] m_addr[2];
  logic [7:0]  m_be  [2];
  logic [63:0] m_data[2];

  task automatic model(input int nb, input bit split, input logic [1:0] size,
                       input logic [31:0] addr, input logic [63:0] data);
    int          bytes;
    int          k;
    int          lane;
    logic [31:0] base;
    logic [31:0] a;
    logic [31:0] w;
    bytes = 1 << size;
    for (int j = 0; j < 2; j++) begin
      m_addr[j] = '0;
      m_be[j]   = '0;
      m_data[j] = '0;
    end
    if (bytes > nb) begin
      m_beats = 0;
    end else begin
      base = addr - (addr % nb);
      for (int i = 0; i < bytes; i++) begin
        a    = addr + i;
        w    = a - (a % nb);
        k    = (w == base) ? 0 : 1;
        lane = int'(a % nb);
        m_addr[k]               = w;
        m_be[k][lane]           = 1'b1;
        m_data[k][8*lane +: 8]  = data[8*i +: 8];
      end
      m_beats = (m_be[1] != 8'd0) ? 2 : 1;
      if (m_beats == 2 && !split) m_beats = 0;
    end
  endtask

  // Starts at a negedge with the unit idle; returns at the negedge after done/exc is expected.
  task automatic do_store(input int d, input logic [1:0] size, input logic [31:0] addr,
                          input logic [63:0] data, input int stall);
    string       t;
    int          nb;
    logic [63:0] dat;
    nb  = (d == 2) ? 8 : 4;
    dat = (nb == 4) ? {32'd0, data[31:0]} : data;
    model(nb, d != 1, size, addr, dat);
    t = $sformatf("u%0d sz%0d @%08h", d, size, addr);
    chk({t, " req_ready idle"}, 64'(o_ready[d]), 64'd1);
    d_valid[d] = 1'b1;
    d_size[d]  = size;
    d_addr[d]  = addr;
    d_wdata[d] = dat;
    @(posedge clk);
    @(negedge clk);
    d_valid[d] = 1'b0;
    if (m_beats == 0) begin
      chk({t, " misalign_exc"}, 64'(o_exc[d]), 64'd1);
      chk({t, " no mem_valid"}, 64'(o_valid[d]), 64'd0);
      chk({t, " no done"}, 64'(o_done[d]), 64'd0);
      chk({t, " bad_addr"}, 64'(o_bad[d]), 64'(addr));
      chk({t, " req_ready after exc"}, 64'(o_ready[d]), 64'd1);
    end else begin
      for (int k = 0; k < m_beats; k++) begin
        for (int s = 0; s <= stall; s++) begin
          chk($sformatf("%s b%0d mem_valid", t, k), 64'(o_valid[d]), 64'd1);
          chk($sformatf("%s b%0d mem_addr", t, k), 64'(o_addr[d]), 64'(m_addr[k]));
          chk($sformatf("%s b%0d mem_be", t, k), 64'(o_be[d]), 64'(m_be[k]));
          chk($sformatf("%s b%0d mem_wdata", t, k), o_wdata[d], m_data[k]);
          chk($sformatf("%s b%0d req_ready busy", t, k), 64'(o_ready[d]), 64'd0);
          chk($sformatf("%s b%0d done low", t, k), 64'(o_done[d] | o_exc[d]), 64'd0);
          if (s < stall) @(negedge clk);
        end
        d_mready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d_mready[d] = 1'b0;
      end
      chk({t, " done"}, 64'(o_done[d]), 64'd1);
      chk({t, " no exc"}, 64'(o_exc[d]), 64'd0);
      chk({t, " mem_valid dropped"}, 64'(o_valid[d]), 64'd0);
      chk({t, " req_ready after done"}, 64'(o_ready[d]), 64'd1);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      d_valid[i]  = 1'b0;
      d_size[i]   = 2'd0;
      d_addr[i]   = '0;
      d_wdata[i]  = '0;
      d_mready[i] = 1'b0;
    end

    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d reset req_ready", i), 64'(o_ready[i]), 64'd0);
      chk($sformatf("u%0d reset mem_valid", i), 64'(o_valid[i]), 64'd0);
      chk($sformatf("u%0d reset mem_addr", i), 64'(o_addr[i]), 64'd0);
      chk($sformatf("u%0d reset mem_be", i), 64'(o_be[i]), 64'd0);
      chk($sformatf("u%0d reset mem_wdata", i), o_wdata[i], 64'd0);
      chk($sformatf("u%0d reset done/exc", i), 64'({o_done[i], o_exc[i]}), 64'd0);
      chk($sformatf("u%0d reset bad_addr", i), 64'(o_bad[i]), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d req_ready after release", i), 64'(o_ready[i]), 64'd1);
    end

    do_store(0, 2'd2, 32'h0000_0100, 64'hDEAD_BEEF, 0);
    for (int a = 0; a < 4; a++) do_store(0, 2'd0, 32'h200 + 32'(a), 64'hAB, 0);
    do_store(0, 2'd1, 32'h0000_0103, 64'h1234, 0);
    do_store(1, 2'd1, 32'h0000_0103, 64'h1234, 0);
    do_store(1, 2'd3, 32'h0000_0400, 64'h1111_2222_3333_4444, 0);
    do_store(0, 2'd3, 32'h0000_0408, 64'h5555_6666_7777_8888, 0);
    do_store(0, 2'd2, 32'h0000_0300, 64'hCAFE_F00D, 3);
    do_store(0, 2'd2, 32'hFFFF_FFFE, 64'h0BAD_C0DE, 0);
    do_store(2, 2'd3, 32'h0000_1004, 64'h0123_4567_89AB_CDEF, 1);
    do_store(2, 2'd3, 32'h0000_2000, 64'hFEDC_BA98_7654_3210, 0);

    // Reset while beat 0 of a split store is back-pressured.
    d_valid[0] = 1'b1;
    d_size[0]  = 2'd2;
    d_addr[0]  = 32'hFFFF_FFFE;
    d_wdata[0] = 64'h1357_9BDF;
    @(posedge clk);
    @(negedge clk);
    d_valid[0] = 1'b0;
    chk("rst-mid beat0 mem_valid", 64'(o_valid[0]), 64'd1);
    chk("rst-mid beat0 mem_be", 64'(o_be[0]), 64'h0C);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst-mid mem_valid cleared", 64'(o_valid[0]), 64'd0);
    chk("rst-mid no done", 64'(o_done[0]), 64'd0);
    chk("rst-mid req_ready low in reset", 64'(o_ready[0]), 64'd0);
    chk("rst-mid u1 bad_addr cleared", 64'(o_bad[1]), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst-mid post mem_valid", 64'(o_valid[0]), 64'd0);
    chk("rst-mid post no done", 64'(o_done[0]), 64'd0);
    chk("rst-mid post req_ready", 64'(o_ready[0]), 64'd1);

    for (int it = 0; it < 90; it++) begin
      int          d;
      logic [1:0]  sz;
      logic [31:0] ad;
      d  = int'($urandom_range(0, 2));
      sz = 2'($urandom_range(0, 3));
      ad = $urandom;
      if (it % 4 == 0) ad = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
      do_store(d, sz, ad, {$urandom, $urandom}, int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/store_align_unit.md
# store_align_unit

Parametrised store path between the MEM-stage address/data and the data-memory port. It accepts one store per request handshake and derives the byte-lane enables and lane-shifted write data for 32- or 64-bit data buses. Stores that cross a bus-word boundary are either split into two memory beats or rejected with a misalignment exception, according to a parameter. It supersedes the fixed 32-bit combinational byte-enable decoder.

## Interface
- DATA_W, 32: memory data width; legal values 32 and 64. NB = DATA_W/8 lanes, OW = log2(NB).
- ADDR_W, 32: byte-address width.
- SPLIT_MISALIGNED, 1: 1 splits boundary-crossing stores into two beats; 0 raises misalign_exc.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  store request present.
- req_ready  out  1  unit idle and able to accept.
- req_size  in  2  log2(bytes): 0 byte, 1 half, 2 word, 3 dword.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- mem_valid  out  1  memory beat valid.
- mem_ready  in  1  memory accepts the beat.
- mem_addr  out  ADDR_W  bus-word-aligned address, low OW bits 0.
- mem_be  out  NB  lane enables.
- mem_wdata  out  DATA_W  lane-shifted data; disabled lanes 0.
- done  out  1  one-cycle pulse: store fully written.
- misalign_exc  out  1  one-cycle pulse: store rejected.
- bad_addr  out  ADDR_W  address of the last rejected store; holds until the next rejection.

## Operation
- States: IDLE, BEAT0, BEAT1. req_ready = (state==IDLE).
- Accept when req_valid && req_ready. On accept, the unit latches size, addr and wdata. off = addr[OW-1:0], bytes = 1<<size, last = off+bytes-1, computed OW+1 bits wide.
- Illegal size: req_size=3 with DATA_W=32. Response: no beat, misalign_exc, bad_addr=req_addr.
- last < NB: single beat. be = ((1<<bytes)-1)<<off, truncated to NB. wdata = req_wdata << 8*off. IDLE→BEAT0; the beat is the final beat.
- last >= NB and SPLIT_MISALIGNED=1: two beats.
  - Beat0: mem_addr = aligned addr. be = lanes off..NB-1. Data = wdata << 8*off.
  - Beat1: mem_addr = aligned addr + NB, mod 2^ADDR_W, so it wraps to 0. be = lanes 0..last-NB. Data = wdata >> 8*(NB-off).
  - Transitions: BEAT0→BEAT1 on handshake.
- last >= NB and SPLIT_MISALIGNED=0: no beat. misalign_exc pulses and bad_addr is captured. The unit stays in IDLE.
- A final-beat handshake (mem_valid && mem_ready) returns the unit to IDLE and registers done.
- Lanes outside be carry zero data.

## Timing
- Reset (rst_n=0 at an edge) forces:
  - state=IDLE;
  - mem_valid=0, mem_be=0, mem_wdata=0, mem_addr=0;
  - done=0, misalign_exc=0, bad_addr=0.
- req_ready is 0 while rst_n=0 and 1 in the first cycle after release.
- Accept at edge T → mem_valid=1 from cycle T+1.
- mem_addr, mem_be and mem_wdata stay stable while mem_valid && !mem_ready.
- Beat0 handshake at T+k of a split store → beat1 is presented at T+k+1.
- Final handshake at edge F → done=1 and req_ready=1 during cycle F+1. A new request may be accepted at F+1. Peak rate: one single-beat store per 2 cycles.
- Rejected store accepted at T → misalign_exc=1 during T+1, with req_ready=1 in the same cycle.
- done and misalign_exc never both 1.
- Reset mid-operation abandons the store. mem_valid is 0 from the next cycle. A beat0 already accepted by memory is not undone.
- mem_ready is ignored while mem_valid=0.

## Structure
- Package store_pkg holds:
  - size encodings SZ_BYTE..SZ_DWORD;
  - state enum (IDLE, BEAT0, BEAT1);
  - function lane_mask(off, count, NB).
- One combinational sub-module, store_lane_gen. Inputs: off, size, beat index. Outputs: be, shift amount, crosses flag, illegal flag. It is parametrised by DATA_W.
- The top level holds the FSM, request latches and output registers.

## Test plan
- DATA_W=32, word store, addr 0x100, data 0xDEADBEEF, mem_ready=1 → at T+1 the beat is addr 0x100, be 1111, data DEADBEEF. At T+2 done=1 and req_ready=1.
- Byte stores at 0x200..0x203, data 0xAB:
  - be 0001/0010/0100/1000;
  - data 0x000000AB, 0x0000AB00, 0x00AB0000, 0xAB000000.
- SPLIT=1, half store at 0x103, data 0x1234:
  - beat0: addr 0x100, be 1000, data 0x34000000;
  - beat1: addr 0x104, be 0001, data 0x00000012;
  - done one cycle after beat1.
- SPLIT=0, same half store → no mem_valid; misalign_exc=1 at T+1; bad_addr=0x103. Additionally, size=3 at DATA_W=32 → misalign_exc=1.
- mem_ready held 0 for 3 cycles on a word store → mem_addr, mem_be and mem_wdata unchanged, and req_ready=0 throughout.
- Word at 0xFFFFFFFE, SPLIT=1 → beat1 addr 0x00000000, be 0011.
- Repeat with rst_n=0 during beat0 backpressure → mem_valid=0 the next cycle and no done pulse.
- DATA_W=64, dword at offset 4 → beat0 be 0xF0, then beat1 be 0x0F.
